// File: rtl/dcache_axi_master.sv
// dcache_axi_master: bridges the L1 data cache memory port onto an AXI4 master.
// Cacheable reads fill a 4-word line; uncached reads and writes are single beats.
module dcache_axi_master #(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] ID_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            D_req,
    input  logic            D_write,
    input  logic [31:0]     D_addr,
    input  logic [31:0]     D_in,
    input  logic [3:0]      D_type,
    output logic [31:0]     D_out,
    output logic            D_wait,
    output logic [ID_W-1:0] ARID,
    output logic [31:0]     ARADDR,
    output logic [3:0]      ARLEN,
    output logic [2:0]      ARSIZE,
    output logic [1:0]      ARBURST,
    output logic            ARVALID,
    input  logic            ARREADY,
    input  logic [ID_W-1:0] RID,
    input  logic [31:0]     RDATA,
    input  logic [1:0]      RRESP,
    input  logic            RLAST,
    input  logic            RVALID,
    output logic            RREADY,
    output logic [ID_W-1:0] AWID,
    output logic [31:0]     AWADDR,
    output logic [3:0]      AWLEN,
    output logic [2:0]      AWSIZE,
    output logic [1:0]      AWBURST,
    output logic            AWVALID,
    input  logic            AWREADY,
    output logic [31:0]     WDATA,
    output logic [3:0]      WSTRB,
    output logic            WLAST,
    output logic            WVALID,
    input  logic            WREADY,
    input  logic [ID_W-1:0] BID,
    input  logic [1:0]      BRESP,
    input  logic            BVALID,
    output logic            BREADY,
    output logic            bus_err
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP
    } state_t;

    state_t      state, state_nx;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q, len_q, cnt_q;
    logic        aw_done, w_done, bus_err_q;
    logic        noncache, last_beat, aw_fire, w_fire;
    logic        unused_ids;

    assign noncache  = (D_addr[31:16] == 16'h1000) ||
                       (D_addr[31:16] == 16'h0010) ||
                       (D_addr[31:16] == 16'h0003);
    assign last_beat = (cnt_q == len_q);
    assign aw_fire   = AWVALID && AWREADY;
    assign w_fire    = WVALID && WREADY;
    assign unused_ids = ^{RID, BID};

    assign ARID    = ID_VAL;
    assign AWID    = ID_VAL;
    assign ARADDR  = addr_q;
    assign AWADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;
    assign bus_err = bus_err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ARVALID  = 1'b0;
        RREADY   = 1'b0;
        AWVALID  = 1'b0;
        WVALID   = 1'b0;
        BREADY   = 1'b0;
        D_wait   = 1'b1;
        D_out    = '0;
        unique case (state)
            IDLE: begin
                if (D_write)    state_nx = WR_REQ;
                else if (D_req) state_nx = RD_ADDR;
            end
            RD_ADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_nx = RD_DATA;
            end
            RD_DATA: begin
                RREADY = 1'b1;
                D_out  = RDATA;
                if (RVALID) begin
                    D_wait = 1'b0;
                    // beat count, not RLAST, decides when the fill ends
                    if (last_beat) state_nx = IDLE;
                end
            end
            WR_REQ: begin
                AWVALID = !aw_done;
                WVALID  = !w_done;
                if ((aw_done || aw_fire) && (w_done || w_fire))
                    state_nx = WR_RESP;
            end
            WR_RESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    D_wait   = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (D_write) begin
                        addr_q  <= D_addr;
                        wdata_q <= D_in;
                        wstrb_q <= ~D_type;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else if (D_req) begin
                        addr_q <= D_addr;
                        len_q  <= noncache ? 4'd0 : 4'd3;
                        cnt_q  <= '0;
                    end
                end
                RD_DATA: begin
                    if (RVALID) begin
                        cnt_q <= cnt_q + 4'd1;
                        if ((RLAST != last_beat) || (RRESP != 2'b00))
                            bus_err_q <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (BVALID && (BRESP != 2'b00)) bus_err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_axi_master.sv
// tb_dcache_axi_master: AXI slave model with configurable stalls and
// response faults; a monitor logs every D_wait=0 cycle for the tests.
module tb_dcache_axi_master;

    localparam int ID_W = 4;

    logic            clk, rst;
    logic            D_req, D_write;
    logic [31:0]     D_addr, D_in;
    logic [3:0]      D_type;
    logic [31:0]     D_out;
    logic            D_wait;
    logic [ID_W-1:0] ARID, RID, AWID, BID;
    logic [31:0]     ARADDR, RDATA, AWADDR, WDATA;
    logic [3:0]      ARLEN, AWLEN, WSTRB;
    logic [2:0]      ARSIZE, AWSIZE;
    logic [1:0]      ARBURST, AWBURST, RRESP, BRESP;
    logic            ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic            AWVALID, AWREADY, WLAST, WVALID, WREADY;
    logic            BVALID, BREADY, bus_err;

    dcache_axi_master #(.ID_W(ID_W), .ID_VAL('0)) dut (
        .clk(clk), .rst(rst),
        .D_req(D_req), .D_write(D_write), .D_addr(D_addr), .D_in(D_in),
        .D_type(D_type), .D_out(D_out), .D_wait(D_wait),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // slave configuration
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0;
    int          b_delay = 0, bad_last_beat = -1, err_beat = -1;
    logic [31:0] rd_data [4];

    // slave state and observations
    int          r_left = 0, r_beat = 0, r_gap = 0;
    int          ar_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    bit          b_pend = 0, aw_got = 0, w_got = 0;
    int          seq = 0, ar_seq = 0, aw_seq = 0, ar_cnt = 0;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [3:0]  s_arlen, s_awlen, s_wstrb;
    logic [2:0]  s_arsize, s_awsize;
    logic [1:0]  s_arburst;
    logic        s_wlast, s_aw_at_w;

    // scoreboard
    logic [31:0] exp_q [$];
    logic [31:0] obs_q [$];
    int          obs_cyc [$];
    logic        obs_wr [$];

    initial begin
        ARREADY = 0; RVALID = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
        RDATA = '0; RRESP = '0; RLAST = 0; RID = '0; BID = '0; BRESP = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ARREADY = 0; RVALID = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
                RLAST = 0; RRESP = '0;
                r_left = 0; b_pend = 0; aw_got = 0; w_got = 0;
                ar_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0; r_gap = 0;
            end else begin
                BVALID = 0;
                if (b_pend) begin
                    if (b_wait >= b_delay) begin
                        BVALID = 1; BRESP = 2'b00;
                        if (BREADY) b_pend = 0;
                    end else b_wait++;
                end
                RVALID = 0; RLAST = 0; RRESP = '0;
                if (r_left > 0) begin
                    if (r_gap >= r_delay) begin
                        RVALID = 1;
                        RDATA  = rd_data[r_beat];
                        RLAST  = (r_left == 1) ^ (r_beat == bad_last_beat);
                        RRESP  = (r_beat == err_beat) ? 2'b10 : 2'b00;
                        if (RREADY) begin r_left--; r_beat++; r_gap = 0; end
                    end else r_gap++;
                end
                ARREADY = 0;
                if (ARVALID) begin
                    if (ar_wait >= ar_delay) begin
                        ARREADY = 1; ar_wait = 0;
                        s_araddr = ARADDR; s_arlen = ARLEN;
                        s_arsize = ARSIZE; s_arburst = ARBURST;
                        r_left = int'(ARLEN) + 1; r_beat = 0; r_gap = 0;
                        ar_cnt++; seq++; ar_seq = seq;
                    end else ar_wait++;
                end
                AWREADY = 0;
                if (AWVALID) begin
                    if (aw_wait >= aw_delay) begin
                        AWREADY = 1; aw_wait = 0; aw_got = 1;
                        s_awaddr = AWADDR; s_awlen = AWLEN; s_awsize = AWSIZE;
                        seq++; aw_seq = seq;
                    end else aw_wait++;
                end
                WREADY = 0;
                if (WVALID) begin
                    if (w_wait >= w_delay) begin
                        WREADY = 1; w_wait = 0; w_got = 1;
                        s_wdata = WDATA; s_wstrb = WSTRB; s_wlast = WLAST;
                        s_aw_at_w = AWVALID;
                    end else w_wait++;
                end
                if (aw_got && w_got) begin
                    b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0;
                end
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (!rst && !D_wait) begin
            obs_q.push_back(D_out);
            obs_cyc.push_back(cyc);
            obs_wr.push_back(BREADY);
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #3; end
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int i = 0; i < budget && obs_q.size() < n; i++) step(1);
    endtask

    task automatic clear_sb();
        exp_q.delete(); obs_q.delete(); obs_cyc.delete(); obs_wr.delete();
    endtask

    function automatic int cyc_at(input int i);
        return (i < obs_cyc.size()) ? obs_cyc[i] : -1;
    endfunction

    task automatic apply_reset();
        step(1);
        rst = 1; D_req = 0; D_write = 0;
        repeat (2) @(posedge clk);
        step(1);
        rst = 0;
        ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
        bad_last_beat = -1; err_beat = -1;
        clear_sb();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ARVALID, RREADY, AWVALID, WVALID, BREADY} !== 5'b0)
            $display("FAIL rst_valids got %b want 00000",
                     {ARVALID, RREADY, AWVALID, WVALID, BREADY});
        else n_pass++;
        n_checks++;
        if ({D_wait, bus_err} !== 2'b10)
            $display("FAIL rst_wait_err got %b want 10", {D_wait, bus_err});
        else n_pass++;
        n_checks++;
        if ({D_out, ARADDR, AWADDR, WDATA, WSTRB} !== '0)
            $display("FAIL rst_regs got %h/%h/%h/%h/%h want 0",
                     D_out, ARADDR, AWADDR, WDATA, WSTRB);
        else n_pass++;
        step(1);
        rst = 0;
        step(1);
    endtask

    task automatic test_cacheable_read();
        int c0, cnt0;
        logic [31:0] e, g;
        clear_sb();
        for (int i = 0; i < 4; i++) begin
            rd_data[i] = 32'hA0 + 32'(i);
            exp_q.push_back(32'hA0 + 32'(i));
        end
        cnt0 = ar_cnt;
        c0 = cyc;
        D_addr = 32'h0000_1230; D_req = 1;
        wait_obs(4, 40);
        D_req = 0;
        step(4);
        n_checks++;
        if (obs_q.size() !== 4)
            $display("FAIL crd_beats got %0d want 4", obs_q.size());
        else n_pass++;
        n_checks++;
        if ({cyc_at(0), cyc_at(3)} !== {c0 + 2, c0 + 5})
            $display("FAIL crd_timing got %0d..%0d want %0d..%0d",
                     cyc_at(0), cyc_at(3), c0 + 2, c0 + 5);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
            n_checks++;
            if (g !== e) $display("FAIL crd_data got %h want %h", g, e);
            else n_pass++;
        end
        n_checks++;
        if ({s_araddr, s_arlen, s_arsize, s_arburst} !==
            {32'h0000_1230, 4'd3, 3'b010, 2'b01})
            $display("FAIL crd_ar got %h/%0d/%0d/%0d want 1230/3/2/1",
                     s_araddr, s_arlen, s_arsize, s_arburst);
        else n_pass++;
        n_checks++;
        if ({ar_cnt - cnt0, ARVALID, RREADY, D_wait} !== {32'd1, 3'b001})
            $display("FAIL crd_idle got ars=%0d arv=%b rr=%b w=%b want 1/0/0/1",
                     ar_cnt - cnt0, ARVALID, RREADY, D_wait);
        else n_pass++;
    endtask

    task automatic test_uncached_read();
        int c0;
        logic [31:0] e, g;
        clear_sb();
        r_delay = 3;
        rd_data[0] = 32'h5555_1234;
        exp_q.push_back(32'h5555_1234);
        c0 = cyc;
        D_addr = 32'h1000_0008; D_req = 1;
        wait_obs(1, 40);
        D_req = 0;
        step(5);
        r_delay = 0;
        n_checks++;
        if (obs_q.size() !== 1)
            $display("FAIL ncrd_beats got %0d want 1", obs_q.size());
        else n_pass++;
        n_checks++;
        if (cyc_at(0) !== c0 + 5)
            $display("FAIL ncrd_timing got %0d want %0d", cyc_at(0), c0 + 5);
        else n_pass++;
        n_checks++;
        if ({s_araddr, s_arlen} !== {32'h1000_0008, 4'd0})
            $display("FAIL ncrd_ar got %h/%0d want 10000008/0",
                     s_araddr, s_arlen);
        else n_pass++;
        e = exp_q.pop_front();
        g = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
        n_checks++;
        if (g !== e) $display("FAIL ncrd_data got %h want %h", g, e);
        else n_pass++;
    endtask

    task automatic test_write();
        clear_sb();
        aw_delay = 0; w_delay = 2;
        D_addr = 32'h0000_2004; D_in = 32'hDEAD_BEEF; D_type = 4'b1100;
        D_write = 1;
        wait_obs(1, 40);
        D_write = 0;
        step(4);
        w_delay = 0;
        n_checks++;
        if ({obs_q.size(), (obs_wr.size() > 0) ? obs_wr[0] : 1'b0} !==
            {32'd1, 1'b1})
            $display("FAIL wr_resp got n=%0d want one write response",
                     obs_q.size());
        else n_pass++;
        n_checks++;
        if ({s_awaddr, s_awlen, s_awsize} !== {32'h0000_2004, 4'd0, 3'b010})
            $display("FAIL wr_aw got %h/%0d/%0d want 2004/0/2",
                     s_awaddr, s_awlen, s_awsize);
        else n_pass++;
        n_checks++;
        if ({s_wdata, s_wstrb, s_wlast} !== {32'hDEAD_BEEF, 4'b0011, 1'b1})
            $display("FAIL wr_w got %h/%b/%b want deadbeef/0011/1",
                     s_wdata, s_wstrb, s_wlast);
        else n_pass++;
        n_checks++;
        if (s_aw_at_w !== 1'b0)
            $display("FAIL wr_aw_drop got awvalid=%b want 0", s_aw_at_w);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int c0;
        logic [31:0] e, g;
        clear_sb();
        for (int i = 0; i < 4; i++) begin
            rd_data[i] = 32'hB0 + 32'(i);
            exp_q.push_back(32'hB0 + 32'(i));
        end
        c0 = cyc;
        D_addr = 32'h0000_3000; D_in = 32'h1234_5678; D_type = 4'b0000;
        D_write = 1; D_req = 1;
        wait_obs(1, 40);
        D_write = 0;
        wait_obs(5, 40);
        D_req = 0;
        step(4);
        n_checks++;
        if ({(obs_wr.size() > 0) ? obs_wr[0] : 1'b0, cyc_at(0)} !==
            {1'b1, c0 + 2})
            $display("FAIL b2b_wr_first got cyc %0d want write at %0d",
                     cyc_at(0), c0 + 2);
        else n_pass++;
        n_checks++;
        if ((aw_seq < ar_seq) !== 1'b1)
            $display("FAIL b2b_order got aw=%0d ar=%0d want aw first",
                     aw_seq, ar_seq);
        else n_pass++;
        n_checks++;
        if (cyc_at(1) !== cyc_at(0) + 3)
            $display("FAIL b2b_gap got %0d want %0d", cyc_at(1), cyc_at(0) + 3);
        else n_pass++;
        n_checks++;
        if (s_wstrb !== 4'b1111)
            $display("FAIL b2b_wstrb got %b want 1111", s_wstrb);
        else n_pass++;
        if (obs_q.size() > 0) void'(obs_q.pop_front());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
            n_checks++;
            if (g !== e) $display("FAIL b2b_data got %h want %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_bus_err(input bit use_slverr);
        clear_sb();
        n_checks++;
        if (bus_err !== 1'b0)
            $display("FAIL berr_pre got %b want 0", bus_err);
        else n_pass++;
        if (use_slverr) err_beat = 1;
        else bad_last_beat = 1;
        for (int i = 0; i < 4; i++) rd_data[i] = 32'hC0 + 32'(i);
        D_addr = 32'h0000_4000; D_req = 1;
        wait_obs(4, 40);
        D_req = 0;
        step(5);
        bad_last_beat = -1; err_beat = -1;
        n_checks++;
        if (obs_q.size() !== 4)
            $display("FAIL berr_beats got %0d want 4", obs_q.size());
        else n_pass++;
        n_checks++;
        if ({bus_err, ARVALID, RREADY} !== 3'b100)
            $display("FAIL berr_sticky got err=%b arv=%b rr=%b want 1/0/0",
                     bus_err, ARVALID, RREADY);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        clear_sb();
        for (int i = 0; i < 4; i++) rd_data[i] = 32'hD0 + 32'(i);
        D_addr = 32'h0000_5000; D_req = 1;
        wait_obs(2, 40);
        rst = 1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({ARVALID, RREADY, AWVALID, WVALID, BREADY} !== 5'b0)
            $display("FAIL mrst_valids got %b want 00000",
                     {ARVALID, RREADY, AWVALID, WVALID, BREADY});
        else n_pass++;
        n_checks++;
        if ({D_wait, bus_err, D_out, ARADDR} !== {2'b10, 64'd0})
            $display("FAIL mrst_state got w=%b err=%b out=%h addr=%h want 1/0/0/0",
                     D_wait, bus_err, D_out, ARADDR);
        else n_pass++;
        D_req = 0;
        step(1);
        rst = 0;
        clear_sb();
        step(4);
        n_checks++;
        if ({obs_q.size(), ARVALID, D_wait} !== {32'd0, 2'b01})
            $display("FAIL mrst_quiet got n=%0d arv=%b w=%b want 0/0/1",
                     obs_q.size(), ARVALID, D_wait);
        else n_pass++;
    endtask

    initial begin
        rst = 1; D_req = 0; D_write = 0;
        D_addr = '0; D_in = '0; D_type = 4'hF;
        test_reset();
        test_cacheable_read();
        test_uncached_read();
        test_write();
        test_back_to_back();
        test_bus_err(1'b0);
        apply_reset();
        test_bus_err(1'b1);
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
